// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: default widths and RV32 load funct3 encodings.
package mem_wb_stage_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Encodings 011/110/111 are not loads on a 32-bit core.
  function automatic logic load_f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load extraction and misalignment check for the MEM/WB stage.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            is_load,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data,
  output logic            fault
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v  = rdata[{offset, 3'b000} +: 8];
    half_v  = rdata[{offset[1], 4'b0000} +: 16];
    ld_data = '0;
    case (funct3)
      LB:      ld_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      LBU:     ld_data = {{(XLEN-8){1'b0}}, byte_v};
      LH:      ld_data = {{(XLEN-16){half_v[15]}}, half_v};
      LHU:     ld_data = {{(XLEN-16){1'b0}}, half_v};
      LW:      ld_data = rdata;
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    fault = 1'b0;
    if (is_load) begin
      fault = load_f3_illegal(funct3)
            || (((funct3 == LH) || (funct3 == LHU)) && offset[0])
            || ((funct3 == LW) && (offset != 2'b00));
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: one-entry register feeding the register-file write port.
// Optional retired-instruction counter enabled by defining MEM_WB_INSTRET_EN.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wreg_en,
  input  logic [REG_ADDR_W-1:0] in_wreg_addr,
  input  logic [XLEN-1:0]       in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_mem_rdata,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  w_enable,
  output logic [REG_ADDR_W-1:0] w_addr,
  output logic [XLEN-1:0]       w_data,
`ifdef MEM_WB_INSTRET_EN
  output logic [63:0]           instret,
`endif
  output logic                  misalign
);

  logic                  valid_q, valid_d;
  logic                  wreg_en_q, wreg_en_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;

  logic            retiring;
  logic            capture;
  logic            fault;
  logic [XLEN-1:0] ld_data;

  load_align #(.XLEN(XLEN)) u_load_align (
    .is_load (is_load_q),
    .funct3  (funct3_q),
    .offset  (result_q[1:0]),
    .rdata   (rdata_q),
    .ld_data (ld_data),
    .fault   (fault)
  );

  // A cycle in which reset is asserted never issues a write.
  assign retiring = rst && valid_q && !stall;
  assign in_ready = !rst || !valid_q || !stall;
  assign capture  = in_valid && in_ready;

  always_comb begin
    w_enable = 1'b0;
    w_addr   = '0;
    w_data   = '0;
    misalign = 1'b0;
    if (retiring) begin
      w_enable = wreg_en_q && (addr_q != '0) && !fault;
      w_addr   = addr_q;
      w_data   = is_load_q ? ld_data : result_q;
      misalign = fault;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    wreg_en_d = wreg_en_q;
    addr_d    = addr_q;
    result_d  = result_q;
    is_load_d = is_load_q;
    funct3_d  = funct3_q;
    rdata_d   = rdata_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      wreg_en_d = in_wreg_en;
      addr_d    = in_wreg_addr;
      result_d  = in_result;
      is_load_d = in_is_load;
      funct3_d  = in_funct3;
      rdata_d   = in_mem_rdata;
    end else if (retiring) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      wreg_en_q <= 1'b0;
      addr_q    <= '0;
      result_q  <= '0;
      is_load_q <= 1'b0;
      funct3_q  <= '0;
      rdata_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      wreg_en_q <= wreg_en_d;
      addr_q    <= addr_d;
      result_q  <= result_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef MEM_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Natural 64-bit overflow provides the wrap to zero.
  always_comb begin
    instret_d = instret_q;
    if (retiring && !fault) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) instret_q <= '0;
    else      instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (instret section built when MEM_WB_INSTRET_EN is defined).
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_wreg_en;
  logic [RAW-1:0]  in_wreg_addr;
  logic [XLEN-1:0] in_result;
  logic            in_is_load;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_mem_rdata;
  logic            stall;
  logic            flush;
  logic            w_enable;
  logic [RAW-1:0]  w_addr;
  logic [XLEN-1:0] w_data;
  logic            misalign;
`ifdef MEM_WB_INSTRET_EN
  logic [63:0]     instret;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wreg_en   (in_wreg_en),
    .in_wreg_addr (in_wreg_addr),
    .in_result    (in_result),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_mem_rdata (in_mem_rdata),
    .stall        (stall),
    .flush        (flush),
    .w_enable     (w_enable),
    .w_addr       (w_addr),
    .w_data       (w_data),
`ifdef MEM_WB_INSTRET_EN
    .instret      (instret),
`endif
    .misalign     (misalign)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [RAW-1:0] rd, input logic [XLEN-1:0] res,
                       input logic ld, input logic [2:0] f3, input logic [XLEN-1:0] rdata);
    in_valid     = 1'b1;
    in_wreg_en   = wen;
    in_wreg_addr = rd;
    in_result    = res;
    in_is_load   = ld;
    in_funct3    = f3;
    in_mem_rdata = rdata;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    #1;
  endtask

  // Capture one instruction then leave the inputs idle so its retire cycle can be observed.
  task automatic send(input logic wen, input logic [RAW-1:0] rd, input logic [XLEN-1:0] res,
                      input logic ld, input logic [2:0] f3, input logic [XLEN-1:0] rdata);
    drive(wen, rd, res, ld, f3, rdata);
    step();
    idle();
  endtask

  task automatic expect_write(input string tag, input logic [RAW-1:0] rd, input logic [XLEN-1:0] data);
    chk({tag, ".wen"}, {63'd0, w_enable}, 64'd1);
    chk({tag, ".addr"}, {59'd0, w_addr}, {59'd0, rd});
    chk({tag, ".data"}, {32'd0, w_data}, {32'd0, data});
    chk({tag, ".mis"}, {63'd0, misalign}, 64'd0);
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, ".wen"}, {63'd0, w_enable}, 64'd0);
    chk({tag, ".addr"}, {59'd0, w_addr}, 64'd0);
    chk({tag, ".data"}, {32'd0, w_data}, 64'd0);
    chk({tag, ".mis"}, {63'd0, misalign}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_wreg_en = 1'b0; in_wreg_addr = '0; in_result = '0;
    in_is_load = 1'b0; in_funct3 = '0; in_mem_rdata = '0;
    step(); step();
    expect_quiet("reset");
    chk("reset.ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    #1;

    // ALU write: exactly one cycle after capture, single pulse
    send(1'b1, 5'd5, 32'h0000_1234, 1'b0, 3'b000, 32'h0);
    expect_write("alu", 5'd5, 32'h0000_1234);
    step();
    expect_quiet("alu.after");

    // Load extraction
    send(1'b1, 5'd6, 32'h0000_1003, 1'b1, LB, 32'h80FF_FFFF);
    expect_write("lb3", 5'd6, 32'hFFFF_FF80);
    send(1'b1, 5'd6, 32'h0000_1003, 1'b1, LBU, 32'h80FF_FFFF);
    expect_write("lbu3", 5'd6, 32'h0000_0080);
    send(1'b1, 5'd8, 32'h0000_2002, 1'b1, LHU, 32'hBEEF_0000);
    expect_write("lhu2", 5'd8, 32'h0000_BEEF);
    send(1'b1, 5'd8, 32'h0000_2002, 1'b1, LH, 32'hBEEF_0000);
    expect_write("lh2", 5'd8, 32'hFFFF_BEEF);
    send(1'b1, 5'd9, 32'h0000_2001, 1'b1, LBU, 32'h1234_5678);
    expect_write("lbu1", 5'd9, 32'h0000_0056);
    send(1'b1, 5'd9, 32'h0000_2000, 1'b1, LW, 32'hDEAD_BEEF);
    expect_write("lw0", 5'd9, 32'hDEAD_BEEF);

    // Faults: single misalign pulse, no register write
    send(1'b1, 5'd7, 32'h0000_3002, 1'b1, LW, 32'hDEAD_BEEF);
    chk("lw2.mis", {63'd0, misalign}, 64'd1);
    chk("lw2.wen", {63'd0, w_enable}, 64'd0);
    step();
    chk("lw2.mis_after", {63'd0, misalign}, 64'd0);
    send(1'b1, 5'd7, 32'h0000_3001, 1'b1, LHU, 32'hDEAD_BEEF);
    chk("lhu1.mis", {63'd0, misalign}, 64'd1);
    chk("lhu1.wen", {63'd0, w_enable}, 64'd0);
    send(1'b1, 5'd7, 32'h0000_3000, 1'b1, 3'b110, 32'hDEAD_BEEF);
    chk("f3_110.mis", {63'd0, misalign}, 64'd1);
    chk("f3_110.wen", {63'd0, w_enable}, 64'd0);
    send(1'b1, 5'd7, 32'h0000_3001, 1'b0, LW, 32'hDEAD_BEEF);
    expect_write("alu_odd", 5'd7, 32'h0000_3001);

    // rd=0 and wreg_en=0 never write
    send(1'b1, 5'd0, 32'h0000_00AA, 1'b0, 3'b000, 32'h0);
    chk("rd0.wen", {63'd0, w_enable}, 64'd0);
    send(1'b0, 5'd3, 32'h0000_00AA, 1'b0, 3'b000, 32'h0);
    chk("nowen.wen", {63'd0, w_enable}, 64'd0);
    step();

    // Back-to-back throughput
    drive(1'b1, 5'd1, 32'h0000_0011, 1'b0, 3'b000, 32'h0);
    step();
    drive(1'b1, 5'd2, 32'h0000_0022, 1'b0, 3'b000, 32'h0);
    #1;
    expect_write("b2b.a", 5'd1, 32'h0000_0011);
    chk("b2b.ready", {63'd0, in_ready}, 64'd1);
    step();
    idle();
    expect_write("b2b.b", 5'd2, 32'h0000_0022);
    step();

    // Stall holds the entry for three cycles, then a single write
    drive(1'b1, 5'd10, 32'h0000_0ABC, 1'b0, 3'b000, 32'h0);
    step();
    in_valid = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.wen", i), {63'd0, w_enable}, 64'd0);
      chk($sformatf("stall%0d.ready", i), {63'd0, in_ready}, 64'd0);
      step();
    end
    stall = 1'b0;
    #1;
    expect_write("stall.release", 5'd10, 32'h0000_0ABC);
    step();
    expect_quiet("stall.after");

    // Flush beats stall and a same-cycle capture
    send(1'b1, 5'd11, 32'h0000_0111, 1'b0, 3'b000, 32'h0);
    step();
    drive(1'b1, 5'd12, 32'h0000_0222, 1'b0, 3'b000, 32'h0);
    step();
    in_valid = 1'b0;
    stall = 1'b1;
    #1;
    flush = 1'b1;
    drive(1'b1, 5'd13, 32'h0000_0333, 1'b0, 3'b000, 32'h0);
    step();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    expect_quiet("flush");
    chk("flush.ready", {63'd0, in_ready}, 64'd1);
    step();
    expect_quiet("flush.after");

    // Reset during a stall abandons the entry
    send(1'b1, 5'd14, 32'h0000_0444, 1'b0, 3'b000, 32'h0);
    stall = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rststall.ready", {63'd0, in_ready}, 64'd1);
    step();
    stall = 1'b0;
    #1;
    expect_quiet("rststall");
    chk("rststall.ready2", {63'd0, in_ready}, 64'd1);
    rst = 1'b1;
    #1;
    expect_quiet("rststall.after");
    step();

`ifdef MEM_WB_INSTRET_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("instret.reset", instret, 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd1, i, 1'b0, 3'b000, 32'h0);
      step();
    end
    idle();
    step();
    chk("instret.ten", instret, 64'd10);
    send(1'b1, 5'd7, 32'h0000_3002, 1'b1, LW, 32'h0);
    step();
    chk("instret.fault", instret, 64'd10);
    @(negedge clk);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    send(1'b1, 5'd1, 32'h0, 1'b0, 3'b000, 32'h0);
    step();
    chk("instret.wrap", instret, 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
